riscv_fetch_unit: RTL and testbench
===================================

# riscv_fetch_unit

Decoupled, parametrised instruction fetch unit that replaces the free-running PC counter feeding the core's instruction address bus. It issues sequential requests over a valid/ready memory port and tolerates variable, in-order response latency. Fetched instructions are buffered with their PCs in a DEPTH-entry queue that the decode stage drains through a valid/ready handshake. A single-cycle redirect port flushes the queue and discards every in-flight response belonging to the old stream.

## Interface
- XLEN, 32, address and PC width.
- DEPTH, 4, instruction queue entries and maximum outstanding requests; power of two, ≥2.
- RESET_PC, 0, first fetch address after reset; must be 4-byte aligned.

- clock  in  1  rising-edge clock; one clock domain.
- reset  in  1  asynchronous, active-low reset.
- redirect_valid  in  1  single-cycle request to restart fetch at redirect_pc.
- redirect_pc  in  XLEN  new fetch address; bits [1:0] ignored, treated as 0.
- mem_req_valid  out  1  fetch request valid.
- mem_req_addr  out  XLEN  fetch address, always 4-byte aligned.
- mem_req_ready  in  1  memory accepts the request this cycle.
- mem_resp_valid  in  1  response data valid; responses return in request order.
- mem_resp_data  in  32  instruction word.
- insn_valid  out  1  queue head valid.
- insn_pc  out  XLEN  PC of the queue head.
- insn_data  out  32  instruction word of the queue head.
- insn_ready  in  1  decode consumes the head this cycle.

## Operation
- State: fetch_pc (next request address), resp_pc (PC of the next accepted response), inflight (0..DEPTH, accepted but unanswered requests), drop (0..DEPTH, in-flight responses to discard), and a DEPTH-entry FIFO of {pc, data} with count 0..DEPTH.
- Credit rule: mem_req_valid = (inflight + count < DEPTH) && !redirect_valid. The queue can never overflow.
- Request accept (valid && ready): fetch_pc += 4, inflight += 1.
- Response with drop > 0: discarded, drop -= 1, inflight -= 1; resp_pc unchanged.
- Response with drop == 0: {resp_pc, mem_resp_data} pushed, resp_pc += 4, inflight -= 1.
- Response with inflight == 0 is a protocol error: ignored, no state change.
- Pop: insn_valid && insn_ready removes the head.
- Redirect cycle:
  - queue count <= 0; fetch_pc and resp_pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - No request issued; insn_valid forced 0, so no pop occurs.
  - A response arriving in the same cycle belongs to the old stream: discarded and decrements inflight.
  - drop <= inflight − (mem_resp_valid ? 1 : 0).
- Back-to-back redirects: the last one wins. Each recomputes drop from the current inflight, so the stale-response count stays exact.
- The memory port permits withdrawal of an unaccepted request on redirect. mem_req_addr may change only when the request is accepted or a redirect occurs.
- Arithmetic: all PC increments are modulo 2^XLEN. 0xFFFF_FFFC + 4 wraps to 0 with no special handling.

## Timing
- Reset (reset low, asynchronous), all outputs:
  - mem_req_valid=0, mem_req_addr=RESET_PC.
  - insn_valid=0, insn_pc=0, insn_data=0.
  - inflight=0, drop=0, count=0, fetch_pc=resp_pc=RESET_PC.
- First rising edge with reset high: mem_req_valid=1, mem_req_addr=RESET_PC, provided no redirect is present.
- Peak throughput is one request per cycle while credit allows, and one instruction per cycle out.
- Fetch latency: a response accepted at edge N gives insn_valid=1 after edge N, in cycle N+1. There is no response-to-output bypass.
- Redirect asserted in cycle R: the queue is empty and insn_valid=0 in cycle R+1. The first request to the new PC is presented in cycle R+1.
- Simultaneous push and pop on a full or non-empty queue: count is unchanged, ordering is preserved.
- Reset asserted mid-operation: all state clears immediately. Responses to pre-reset requests are the memory model's responsibility to suppress.

## Test plan
- Reset, then zero-wait memory (ready=1, 1-cycle response), insn_ready=1: requests 0x0, 0x4, 0x8 on consecutive cycles. Sustained insn_valid with insn_pc 0x0, 0x4, 0x8 and no bubbles after the first.
- insn_ready=0, DEPTH=4: exactly 4 requests accepted, then mem_req_valid=0. Queue full, no overflow. Releasing insn_ready restores issue one cycle after the first pop.
- 3-cycle response latency, then redirect to 0x1002 while 3 requests are outstanding: all 3 stale responses discarded. Next insn_pc=0x1000, then 0x1004.
- Redirect in the same cycle as an old-stream response: that response is dropped. drop = inflight−1, and no stale PC reaches the output.
- RESET_PC=0xFFFFFFF8: outputs 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000 in order.
- Reset asserted with 2 queued entries and 2 in flight: insn_valid=0 and mem_req_valid=0 asynchronously. After release, refetch starts from RESET_PC.

Source files
------------

// File: rtl/riscv_fetch_unit_if.sv
// riscv_fetch_unit_if: bundles the fetch unit's redirect, memory and decode
// handshakes.
//   master : fetch unit side (drives mem_req_*, insn_*)
//   slave  : environment side (memory, decode, redirect source)
interface riscv_fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            mem_req_valid;
    logic [XLEN-1:0] mem_req_addr;
    logic            mem_req_ready;
    logic            mem_resp_valid;
    logic [31:0]     mem_resp_data;
    logic            insn_valid;
    logic [XLEN-1:0] insn_pc;
    logic [31:0]     insn_data;
    logic            insn_ready;

    modport master (
        input  redirect_valid, redirect_pc, mem_req_ready, mem_resp_valid,
               mem_resp_data, insn_ready,
        output mem_req_valid, mem_req_addr, insn_valid, insn_pc, insn_data
    );

    modport slave (
        output redirect_valid, redirect_pc, mem_req_ready, mem_resp_valid,
               mem_resp_data, insn_ready,
        input  mem_req_valid, mem_req_addr, insn_valid, insn_pc, insn_data
    );
endinterface

// File: rtl/riscv_fetch_unit.sv
// riscv_fetch_unit: decoupled instruction fetch.
// Issues sequential word fetches over a valid/ready memory port, accepts
// in-order responses of any latency, and buffers {pc, insn} in a DEPTH-entry
// queue drained by decode. A redirect flushes the queue and arranges for all
// responses still in flight to be discarded.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : riscv_fetch_unit_if.master (redirect, mem_req/resp, insn)
module riscv_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    riscv_fetch_unit_if.master     bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     data;
    } entry_t;

    logic            run_q, run_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    entry_t          fifo_q [DEPTH];
    entry_t          fifo_d [DEPTH];

    logic [XLEN-1:0] redir_pc;
    logic [CW:0]     occupancy;
    logic            credit, req_fire, resp_ok, push, pop;
    logic            unused_redir_lsbs;

    assign redir_pc          = {bus.redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redir_lsbs = ^bus.redirect_pc[1:0];

    // Outstanding requests plus queued entries never exceed DEPTH, so every
    // response that is kept always has a free slot.
    assign occupancy = {1'b0, inflight_q} + {1'b0, count_q};
    assign credit    = occupancy < (CW+1)'(DEPTH);

    // run_q holds off the first request until the first edge out of reset.
    assign bus.mem_req_valid = run_q && credit && !bus.redirect_valid;
    assign bus.mem_req_addr  = fetch_pc_q;
    assign bus.insn_valid    = (count_q != '0) && !bus.redirect_valid;
    assign bus.insn_pc       = fifo_q[rd_ptr_q].pc;
    assign bus.insn_data     = fifo_q[rd_ptr_q].data;

    assign req_fire = bus.mem_req_valid && bus.mem_req_ready;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign resp_ok  = bus.mem_resp_valid && (inflight_q != '0);
    assign push     = resp_ok && !bus.redirect_valid && (drop_q == '0);
    assign pop      = bus.insn_valid && bus.insn_ready;

    always_comb begin
        run_d      = 1'b1;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        fifo_d     = fifo_q;

        if (bus.redirect_valid) begin
            // Everything still outstanding belongs to the old stream; a
            // response landing this same cycle is already one of them.
            fetch_pc_d = redir_pc;
            resp_pc_d  = redir_pc;
            inflight_d = inflight_q - CW'(resp_ok);
            drop_d     = inflight_q - CW'(resp_ok);
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
            inflight_d = inflight_q + CW'(req_fire) - CW'(resp_ok);
            if (resp_ok && (drop_q != '0)) drop_d = drop_q - CW'(1);
            if (push) begin
                fifo_d[wr_ptr_q] = '{pc: resp_pc_q, data: bus.mem_resp_data};
                wr_ptr_d         = wr_ptr_q + AW'(1);
                resp_pc_d        = resp_pc_q + XLEN'(4);
            end
            if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q      <= 1'b0;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            run_q      <= run_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            fifo_q     <= fifo_d;
        end
    end
endmodule

// File: tb/tb_riscv_fetch_unit.sv
// tb_riscv_fetch_unit: drives the fetch unit with a latency-configurable
// in-order memory and a decode sink, and checks every cycle against a
// request-tagging reference model (each outstanding request remembers its
// address and whether a redirect has orphaned it).
module tb_riscv_fetch_unit;
    localparam int          XLEN    = 32;
    localparam int          DEPTH   = 4;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    riscv_fetch_unit_if #(.XLEN(XLEN)) ifc ();
    riscv_fetch_unit_if #(.XLEN(XLEN)) ifc2 ();

    riscv_fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .bus(ifc));
    riscv_fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(WRAP_PC)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(ifc2));

    typedef struct { logic [31:0] pc; logic stale; int due; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } ins_t;
    typedef struct {
        logic        ready, iready;
        logic        exp_rv;
        logic [31:0] exp_addr;
        logic        exp_iv;
        logic [31:0] exp_pc;
    } vec_t;

    req_t        pend[$];
    ins_t        refq[$];
    logic [31:0] seen[$];
    logic [31:0] seen2[$];
    logic [31:0] mpc;
    bit          running;
    int          cyc;
    int          ready_pct, iready_pct, resp_pct, lat_min, lat_max;
    logic        w_pend;
    logic [31:0] w_addr;
    logic        s_rv, s_iv;
    logic [31:0] s_addr, s_pc;
    int          n_acc;
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic logic [31:0] word_of(input logic [31:0] pc);
        return {pc[15:0], pc[31:16]} ^ 32'h5A5A_F00D;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive, settle, compare with the model, advance.
    task automatic cycle(input logic redir, input logic [31:0] rpc);
        logic exp_rv, exp_iv, fire, resp, pop;
        logic n_wp;
        logic [31:0] n_wa;
        req_t r;
        ifc.redirect_valid = redir;
        ifc.redirect_pc    = rpc;
        ifc.mem_req_ready  = ($urandom_range(99) < ready_pct);
        ifc.insn_ready     = ($urandom_range(99) < iready_pct);
        resp = (pend.size() > 0) && (pend[0].due <= cyc) && ($urandom_range(99) < resp_pct);
        ifc.mem_resp_valid = resp;
        ifc.mem_resp_data  = resp ? word_of(pend[0].pc) : $urandom();
        ifc2.redirect_valid = 1'b0;
        ifc2.redirect_pc    = '0;
        ifc2.mem_req_ready  = 1'b1;
        ifc2.insn_ready     = 1'b1;
        ifc2.mem_resp_valid = w_pend;
        ifc2.mem_resp_data  = w_addr;
        #1;
        exp_rv = running && !redir && (pend.size() + refq.size() < DEPTH);
        exp_iv = !redir && (refq.size() > 0);
        s_rv = ifc.mem_req_valid; s_addr = ifc.mem_req_addr;
        s_iv = ifc.insn_valid;    s_pc   = ifc.insn_pc;
        chk("mem_req_valid", {31'b0, ifc.mem_req_valid}, {31'b0, exp_rv});
        if (exp_rv && ifc.mem_req_valid) chk("mem_req_addr", ifc.mem_req_addr, mpc);
        chk("insn_valid", {31'b0, ifc.insn_valid}, {31'b0, exp_iv});
        if (exp_iv && ifc.insn_valid) begin
            chk("insn_pc", ifc.insn_pc, refq[0].pc);
            chk("insn_data", ifc.insn_data, refq[0].data);
        end
        if (ifc.mem_req_valid && ifc.mem_req_ready) n_acc++;
        if (ifc.insn_valid && ifc.insn_ready) seen.push_back(ifc.insn_pc);
        if (ifc2.insn_valid && seen2.size() < 3) seen2.push_back(ifc2.insn_pc);
        n_wp = ifc2.mem_req_valid;
        n_wa = ifc2.mem_req_addr;
        fire = exp_rv && ifc.mem_req_ready;
        pop  = exp_iv && ifc.insn_ready;
        if (resp) r = pend.pop_front();
        if (redir) begin
            foreach (pend[i]) pend[i].stale = 1'b1;
            refq.delete();
            mpc = rpc & ~32'h3;
        end else begin
            if (pop) void'(refq.pop_front());
            if (resp && !r.stale) refq.push_back('{r.pc, word_of(r.pc)});
            if (fire) begin
                pend.push_back('{mpc, 1'b0, cyc + $urandom_range(lat_max, lat_min)});
                mpc += 32'd4;
            end
        end
        @(posedge clk);
        cyc++;
        running = rst_n;
        w_pend  = n_wp;
        w_addr  = n_wa;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_req_valid",  {31'b0, ifc.mem_req_valid}, 32'd0);
        chk("rst_req_addr",   ifc.mem_req_addr, 32'h0);
        chk("rst_insn_valid", {31'b0, ifc.insn_valid}, 32'd0);
        chk("rst_insn_pc",    ifc.insn_pc, 32'h0);
        chk("rst_insn_data",  ifc.insn_data, 32'h0);
        chk("rst2_req_valid", {31'b0, ifc2.mem_req_valid}, 32'd0);
        chk("rst2_req_addr",  ifc2.mem_req_addr, WRAP_PC);
        pend.delete(); refq.delete(); seen.delete();
        mpc = 32'h0; running = 0; w_pend = 1'b0; w_addr = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_until_seen(input int n, input int budget);
        for (int i = 0; i < budget && seen.size() < n; i++) cycle(1'b0, '0);
    endtask

    vec_t vt [7];

    initial begin
        cyc = 0; n_acc = 0;
        ready_pct = 100; iready_pct = 100; resp_pct = 100; lat_min = 1; lat_max = 1;
        ifc.redirect_valid = 0; ifc.redirect_pc = 0; ifc.mem_req_ready = 0;
        ifc.mem_resp_valid = 0; ifc.mem_resp_data = 0; ifc.insn_ready = 0;
        ifc2.redirect_valid = 0; ifc2.redirect_pc = 0; ifc2.mem_req_ready = 0;
        ifc2.mem_resp_valid = 0; ifc2.mem_resp_data = 0; ifc2.insn_ready = 0;
        @(negedge clk);
        do_reset();

        // Zero-wait memory, 1-cycle response, decode always ready.
        vt[0] = '{1, 1, 0, 32'h0,  0, 32'h0};
        vt[1] = '{1, 1, 1, 32'h0,  0, 32'h0};
        vt[2] = '{1, 1, 1, 32'h4,  0, 32'h0};
        vt[3] = '{1, 1, 1, 32'h8,  1, 32'h0};
        vt[4] = '{1, 1, 1, 32'hC,  1, 32'h4};
        vt[5] = '{1, 1, 1, 32'h10, 1, 32'h8};
        vt[6] = '{1, 1, 1, 32'h14, 1, 32'hC};
        for (int i = 0; i < 7; i++) begin
            ready_pct  = vt[i].ready  ? 100 : 0;
            iready_pct = vt[i].iready ? 100 : 0;
            cycle(1'b0, '0);
            chk("tbl_req_valid", {31'b0, s_rv}, {31'b0, vt[i].exp_rv});
            if (vt[i].exp_rv) chk("tbl_req_addr", s_addr, vt[i].exp_addr);
            chk("tbl_insn_valid", {31'b0, s_iv}, {31'b0, vt[i].exp_iv});
            if (vt[i].exp_iv) chk("tbl_insn_pc", s_pc, vt[i].exp_pc);
        end

        // Redirect with three requests outstanding at 3-cycle latency.
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 20 && pend.size() != 3; i++) cycle(1'b0, '0);
        chk("reach_3_inflight", pend.size(), 3);
        seen.delete();
        cycle(1'b1, 32'h1002);
        run_until_seen(2, 30);
        chk("redir_seen_cnt", seen.size(), 2);
        if (seen.size() >= 2) begin
            chk("redir_pc0", seen[0], 32'h1000);
            chk("redir_pc1", seen[1], 32'h1004);
        end

        // Redirect in the same cycle as an old-stream response.
        lat_min = 2; lat_max = 2;
        for (int i = 0; i < 20; i++) begin
            if (pend.size() >= 2 && pend[0].due <= cyc && !pend[0].stale) break;
            cycle(1'b0, '0);
        end
        chk("resp_on_redir_setup", (pend.size() >= 2 && pend[0].due <= cyc) ? 1 : 0, 1);
        seen.delete();
        cycle(1'b1, 32'h2000);
        run_until_seen(1, 30);
        chk("redir_resp_pc0", (seen.size() > 0) ? seen[0] : 32'hDEAD_BEEF, 32'h2000);

        // Back-to-back redirects: the second wins.
        seen.delete();
        cycle(1'b1, 32'h4000);
        cycle(1'b1, 32'h5007);
        run_until_seen(1, 30);
        chk("b2b_pc0", (seen.size() > 0) ? seen[0] : 32'hDEAD_BEEF, 32'h5004 & ~32'h7 | 32'h5004);

        // Address wrap through a redirect, and on the RESET_PC=0xFFFFFFF8 instance.
        seen.delete();
        cycle(1'b1, WRAP_PC);
        run_until_seen(3, 40);
        chk("wrap_seen_cnt", seen.size(), 3);
        if (seen.size() >= 3) begin
            chk("wrap_pc0", seen[0], 32'hFFFF_FFF8);
            chk("wrap_pc1", seen[1], 32'hFFFF_FFFC);
            chk("wrap_pc2", seen[2], 32'h0000_0000);
        end
        chk("rstpc_seen_cnt", seen2.size(), 3);
        if (seen2.size() >= 3) begin
            chk("rstpc_pc0", seen2[0], 32'hFFFF_FFF8);
            chk("rstpc_pc1", seen2[1], 32'hFFFF_FFFC);
            chk("rstpc_pc2", seen2[2], 32'h0000_0000);
        end

        // Reset asserted with two queued entries and two in flight.
        cycle(1'b1, 32'h3000);
        iready_pct = 0; lat_min = 3; lat_max = 3;
        for (int i = 0; i < 30; i++) begin
            if (refq.size() == 2 && pend.size() == 2) break;
            cycle(1'b0, '0);
        end
        chk("midrst_setup", (refq.size() == 2 && pend.size() == 2) ? 1 : 0, 1);
        do_reset();

        // Full queue with decode stalled: exactly DEPTH requests accepted.
        lat_min = 1; lat_max = 1; n_acc = 0;
        repeat (12) cycle(1'b0, '0);
        chk("full_acc_cnt", n_acc, DEPTH);
        chk("full_req_valid", {31'b0, s_rv}, 32'd0);
        chk("full_insn_valid", {31'b0, s_iv}, 32'd1);
        iready_pct = 100;
        cycle(1'b0, '0);
        chk("pop_cycle_req_valid", {31'b0, s_rv}, 32'd0);
        cycle(1'b0, '0);
        chk("after_pop_req_valid", {31'b0, s_rv}, 32'd1);
        chk("refetch_first_pc", (seen.size() > 0) ? seen[0] : 32'hDEAD_BEEF, 32'h0);

        // Randomised traffic with occasional redirects.
        ready_pct = 70; iready_pct = 60; resp_pct = 70; lat_min = 1; lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) < 3)
                cycle(1'b1, ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(15)) : $urandom());
            else
                cycle(1'b0, '0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
